// File: rtl/sap_pkg.sv
// Shared SAP datapath definitions: default widths, the W-bus word type and
// the released-bus pattern.
package sap_pkg;

    localparam int SAP_BUS_WIDTH = 8;
    localparam int SAP_PC_WIDTH  = 4;

    typedef logic [SAP_BUS_WIDTH-1:0] w_bus_t;

    localparam logic   SAP_Z_BIT = 1'bz;
    localparam w_bus_t SAP_BUS_Z = {SAP_BUS_WIDTH{1'bz}};

endpackage : sap_pkg

// File: rtl/sap_pc_bit.sv
// One program-counter stage: a JK flip-flop with J=K=tgl_en_i (toggle stage),
// plus a synchronous parallel load used for jumps.
module sap_pc_bit (
    input  logic CLK,
    input  logic CLR,
    input  logic HLT,
    input  logic tgl_en_i,
    input  logic load_i,
    input  logic load_data_i,
    output logic Q
);

    logic q_q;
    logic q_d;

    // Reset is decided first so X on the enables cannot leak into the reset value.
    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = 1'b0;
        end else if (HLT) begin
            q_d = q_q;
        end else if (load_i) begin
            q_d = load_data_i;
        end else if (tgl_en_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge CLK) begin
        q_q <= q_d;
    end

    assign Q = q_q;

endmodule : sap_pc_bit

// File: rtl/sap_program_counter.sv
// SAP program counter: WIDTH toggle stages with synchronous carry lookahead,
// tri-state W-bus drive, and an optional W-bus load (macro SAP_PC_LOAD_EN).
module sap_program_counter
    import sap_pkg::*;
#(
    parameter int WIDTH     = SAP_PC_WIDTH,
    parameter int BUS_WIDTH = SAP_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 HLT,
    input  logic                 CP,
    input  logic                 EP,
`ifdef SAP_PC_LOAD_EN
    input  logic                 LP,
    input  logic [BUS_WIDTH-1:0] W_BUS_IN,
`endif
    output logic [BUS_WIDTH-1:0] W_BUS_OUT,
    output logic [WIDTH-1:0]     PC,
    output logic                 TC
);

    if (WIDTH < 2 || WIDTH > 8 || BUS_WIDTH < WIDTH) begin : g_bad_param
        $error("sap_program_counter: WIDTH must be 2..8 and BUS_WIDTH >= WIDTH");
    end

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] tgl_en;
    logic             load_en;
    logic [WIDTH-1:0] load_data;

`ifdef SAP_PC_LOAD_EN
    assign load_en   = LP;
    assign load_data = W_BUS_IN[WIDTH-1:0];

    if (BUS_WIDTH > WIDTH) begin : g_bus_hi
        logic unused_bus_hi;
        assign unused_bus_hi = ^W_BUS_IN[BUS_WIDTH-1:WIDTH];
    end
`else
    assign load_en   = 1'b0;
    assign load_data = '0;
`endif

    // Each stage toggles when every lower stage is 1; all stages share one edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign tgl_en[i] = CP;
        end else begin : g_upper
            assign tgl_en[i] = CP & (&pc_q[i-1:0]);
        end

        sap_pc_bit u_bit (
            .CLK         (CLK),
            .CLR         (CLR),
            .HLT         (HLT),
            .tgl_en_i    (tgl_en[i]),
            .load_i      (load_en),
            .load_data_i (load_data[i]),
            .Q           (pc_q[i])
        );
    end

    assign PC        = pc_q;
    assign TC        = (&pc_q) & CP & ~HLT & ~CLR;
    assign W_BUS_OUT = EP ? BUS_WIDTH'(pc_q) : {BUS_WIDTH{SAP_Z_BIT}};

endmodule : sap_program_counter
